// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode encodings and timing constants
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    localparam int SCK_MIN_PHASE = 3;

    // Data is sampled on rising SCK whenever CPOL equals CPHA.
    function automatic logic sample_on_rise(input spi_mode_e mode);
        return (mode == MODE0) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with pointer-wrap full/empty
module sync_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              empty;
    logic              full;
    logic              wr_en;
    logic              rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A full FIFO still accepts a write when the head is leaving on the same cycle.
    assign s_tready = ~full | m_tready;
    assign wr_en    = s_tvalid & s_tready;
    assign rd_en    = m_tready & ~empty;

    assign m_tvalid = ~empty;
    assign m_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign level    = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampling SPI slave receiver feeding a word FIFO
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          SCK,
    input  logic                          MOSI,
    input  logic                          SSEL,
    output logic [WORD_W-1:0]             rx_data,
    output logic                          rx_first,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          frame_active,
    output logic                          frame_end,
    output logic                          overflow,
    input  logic                          clr_overflow
);
    localparam int   CNT_W       = $clog2(WORD_W + 1);
    localparam logic SAMPLE_RISE = sample_on_rise(spi_mode_e'({CPOL, CPHA}));

    logic [2:0]        sck_sr;
    logic [2:0]        mosi_sr;
    logic [2:0]        ssel_sr;
    logic              sck_rise;
    logic              sck_fall;
    logic              ssel_fall;
    logic              ssel_rise;
    logic              sample;
    logic              push;
    logic              fifo_ready;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shift_next;
    logic              first_flag;
    logic [WORD_W:0]   head;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sck_sr  <= {3{CPOL}};
            mosi_sr <= 3'b000;
            ssel_sr <= 3'b111;
        end else begin
            sck_sr  <= {sck_sr[1:0], SCK};
            mosi_sr <= {mosi_sr[1:0], MOSI};
            ssel_sr <= {ssel_sr[1:0], SSEL};
        end
    end

    assign sck_rise  =  sck_sr[1] & ~sck_sr[2];
    assign sck_fall  = ~sck_sr[1] &  sck_sr[2];
    assign ssel_fall = ~ssel_sr[1] &  ssel_sr[2];
    assign ssel_rise =  ssel_sr[1] & ~ssel_sr[2];

    assign frame_active = ~ssel_sr[1];
    assign sample       = (SAMPLE_RISE ? sck_rise : sck_fall) & ~ssel_sr[1] & ~ssel_fall;
    assign push         = sample && (bit_cnt == CNT_W'(WORD_W - 1));

    // MOSI is taken from the history flop: it was captured closest to the SCK pin edge.
    always_comb begin
        shift_next = shreg;
        if (MSB_FIRST) begin
            shift_next = {shreg[WORD_W-2:0], mosi_sr[2]};
        end else begin
            shift_next = {mosi_sr[2], shreg[WORD_W-1:1]};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            first_flag <= 1'b0;
            frame_end  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_end <= ssel_rise;
            if (ssel_fall) begin
                bit_cnt    <= '0;
                shreg      <= '0;
                first_flag <= 1'b1;
            end else if (ssel_rise) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (sample) begin
                shreg <= shift_next;
                if (push) begin
                    bit_cnt    <= '0;
                    first_flag <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (push && !fifo_ready) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DATA_W (WORD_W + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .s_tdata  ({first_flag, shift_next}),
        .s_tvalid (push),
        .s_tready (fifo_ready),
        .m_tdata  (head),
        .m_tvalid (rx_valid),
        .m_tready (rx_ready),
        .level    (rx_level)
    );

    assign rx_first = head[WORD_W];
    assign rx_data  = head[WORD_W-1:0];

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - randomized self-checking bench for spi_frame_rx
module tb_spi_frame_rx;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;

    logic        sck0 = 1'b0, mosi0 = 1'b0, ssel0 = 1'b1, rx_ready0 = 1'b0, clr0 = 1'b0;
    logic [7:0]  rx_data0;
    logic        rx_first0, rx_valid0, frame_active0, frame_end0, overflow0;
    logic [2:0]  rx_level0;

    logic        sck3 = 1'b1, mosi3 = 1'b0, ssel3 = 1'b1, rx_ready3 = 1'b0, clr3 = 1'b0;
    logic [15:0] rx_data3;
    logic        rx_first3, rx_valid3, frame_active3, frame_end3, overflow3;
    logic [4:0]  rx_level3;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hp       = 6;
    int          fa_bad   = 0;
    int          fe0_cnt  = 0;
    logic [16:0] q0[$];
    logic [16:0] q3[$];
    bit          ovf0_m   = 0;
    logic [31:0] tx_words[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (frame_end0 === 1'b1) fe0_cnt++;
    end

    spi_frame_rx #(.WORD_W(8), .FIFO_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SCK(sck0), .MOSI(mosi0), .SSEL(ssel0),
        .rx_data(rx_data0), .rx_first(rx_first0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .rx_level(rx_level0), .frame_active(frame_active0), .frame_end(frame_end0),
        .overflow(overflow0), .clr_overflow(clr0)
    );

    spi_frame_rx #(.WORD_W(16), .FIFO_DEPTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut3 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SCK(sck3), .MOSI(mosi3), .SSEL(ssel3),
        .rx_data(rx_data3), .rx_first(rx_first3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
        .rx_level(rx_level3), .frame_active(frame_active3), .frame_end(frame_end3),
        .overflow(overflow3), .clr_overflow(clr3)
    );

    task automatic half();
        repeat (hp) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_sck(input int d, input logic v);
        if (d == 0) sck0 = v; else sck3 = v;
    endtask

    task automatic set_mosi(input int d, input logic v);
        if (d == 0) mosi0 = v; else mosi3 = v;
    endtask

    task automatic set_ssel(input int d, input logic v);
        if (d == 0) ssel0 = v; else ssel3 = v;
    endtask

    // Bus-level word transmit: dut0 is mode 0 MSB-first, dut3 is mode 3 LSB-first.
    task automatic send_word(input int d, input logic [31:0] data, input int nbits, input bit pop_last);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = (d == 0) ? data[7 - i] : data[i];
            if (d == 0) begin
                set_mosi(0, b);
                half();
                set_sck(0, 1'b1);
                if (pop_last && i == nbits - 1) begin
                    @(posedge CLOCK_50);
                    @(posedge CLOCK_50);
                    #1 rx_ready0 = 1'b1;
                    @(posedge CLOCK_50);
                    #1 rx_ready0 = 1'b0;
                    repeat (hp - 3) @(posedge CLOCK_50);
                    #1;
                end else begin
                    half();
                end
                set_sck(0, 1'b0);
            end else begin
                set_sck(3, 1'b0);
                set_mosi(3, b);
                half();
                if (frame_active3 !== 1'b1) fa_bad++;
                set_sck(3, 1'b1);
                half();
            end
        end
    endtask

    task automatic model_push(input int d, input logic [31:0] w, input logic first);
        if (d == 0) begin
            if (q0.size() < 4) q0.push_back({first, 8'h00, w[7:0]});
            else ovf0_m = 1;
        end else begin
            if (q3.size() < 16) q3.push_back({first, w[15:0]});
        end
    endtask

    task automatic frame(input int d, input int pbits, input logic [31:0] pdata, input bit pop_last);
        int w;
        w = (d == 0) ? 8 : 16;
        set_ssel(d, 1'b0);
        half();
        for (int i = 0; i < tx_words.size(); i++) begin
            bit pl;
            pl = pop_last && (i == tx_words.size() - 1);
            send_word(d, tx_words[i], w, pl);
            if (pl && d == 0) void'(q0.pop_front());
            model_push(d, tx_words[i], i == 0);
        end
        if (pbits > 0) send_word(d, pdata, pbits, 1'b0);
        half();
        set_ssel(d, 1'b1);
        half();
        half();
    endtask

    task automatic drain(input int d, input string name);
        int          lvl;
        logic [16:0] got;
        logic [16:0] exp;
        lvl = (d == 0) ? int'(rx_level0) : int'(rx_level3);
        n_checks++;
        if (lvl !== ((d == 0) ? q0.size() : q3.size())) begin
            n_fail++;
            $display("FAIL %s level: got %0d expected %0d", name, lvl, (d == 0) ? q0.size() : q3.size());
        end
        while ((d == 0) ? (q0.size() > 0) : (q3.size() > 0)) begin
            exp = (d == 0) ? q0.pop_front() : q3.pop_front();
            got = (d == 0) ? {rx_first0, 8'h00, rx_data0} : {rx_first3, rx_data3};
            n_checks++;
            if (((d == 0) ? rx_valid0 : rx_valid3) !== 1'b1) begin
                n_fail++;
                $display("FAIL %s rx_valid: got 0 expected 1", name);
            end
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s word: got first=%0d data=%h expected first=%0d data=%h",
                         name, got[16], got[15:0], exp[16], exp[15:0]);
            end
            if (d == 0) rx_ready0 = 1'b1; else rx_ready3 = 1'b1;
            @(posedge CLOCK_50);
            #1;
            rx_ready0 = 1'b0;
            rx_ready3 = 1'b0;
        end
        n_checks++;
        if (((d == 0) ? rx_valid0 : rx_valid3) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s empty after drain: rx_valid still 1", name);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({rx_valid0, rx_level0, rx_data0, rx_first0, frame_active0, frame_end0, overflow0} !== 15'd0) begin
            n_fail++;
            $display("FAIL %s dut0 outputs: valid=%0d level=%0d data=%h first=%0d active=%0d end=%0d ovf=%0d expected all 0",
                     name, rx_valid0, rx_level0, rx_data0, rx_first0, frame_active0, frame_end0, overflow0);
        end
        n_checks++;
        if ({rx_valid3, rx_level3, rx_data3, rx_first3, frame_active3, frame_end3, overflow3} !== 26'd0) begin
            n_fail++;
            $display("FAIL %s dut3 outputs: valid=%0d level=%0d data=%h expected all 0",
                     name, rx_valid3, rx_level3, rx_data3);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge CLOCK_50);
        #1;
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        repeat (4) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_mode0_frame();
        int fe_before;
        hp = 50;
        fe_before = fe0_cnt;
        tx_words = '{32'hAA, 32'h55, 32'h00};
        frame(0, 0, 0, 1'b0);
        n_checks++;
        if (fe0_cnt - fe_before !== 1) begin
            n_fail++;
            $display("FAIL mode0 frame_end pulses: got %0d expected 1", fe0_cnt - fe_before);
        end
        drain(0, "mode0_frame");
        hp = 6;
    endtask

    task automatic test_mode3_lsb();
        fa_bad = 0;
        tx_words = '{32'h1234};
        frame(3, 0, 0, 1'b0);
        n_checks++;
        if (fa_bad !== 0) begin
            n_fail++;
            $display("FAIL mode3 frame_active: low at %0d sample points expected 0", fa_bad);
        end
        n_checks++;
        if (frame_active3 !== 1'b0) begin
            n_fail++;
            $display("FAIL mode3 frame_active after frame: got %0d expected 0", frame_active3);
        end
        drain(3, "mode3_lsb");
    endtask

    task automatic test_partial();
        tx_words.delete();
        frame(0, 5, 32'hFF, 1'b0);
        n_checks++;
        if (rx_level0 !== 3'd0 || overflow0 !== 1'b0) begin
            n_fail++;
            $display("FAIL partial discard: level=%0d ovf=%0d expected 0 0", rx_level0, overflow0);
        end
        tx_words = '{32'h0F};
        frame(0, 0, 0, 1'b0);
        drain(0, "after_partial");
    endtask

    task automatic test_overflow();
        tx_words.delete();
        for (int i = 0; i < 6; i++) tx_words.push_back($urandom_range(0, 255));
        frame(0, 0, 0, 1'b0);
        n_checks++;
        if (int'(rx_level0) !== q0.size()) begin
            n_fail++;
            $display("FAIL overflow level: got %0d expected %0d", rx_level0, q0.size());
        end
        n_checks++;
        if (overflow0 !== ovf0_m) begin
            n_fail++;
            $display("FAIL overflow flag: got %0d expected %0d", overflow0, ovf0_m);
        end
        n_checks++;
        if ({rx_first0, 8'h00, rx_data0} !== q0[0]) begin
            n_fail++;
            $display("FAIL overflow head: got first=%0d data=%h expected first=1 data=%h",
                     rx_first0, rx_data0, q0[0][7:0]);
        end
        clr0 = 1'b1;
        @(posedge CLOCK_50);
        #1 clr0 = 1'b0;
        ovf0_m = 0;
        n_checks++;
        if (overflow0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_overflow: got %0d expected 0", overflow0);
        end
    endtask

    task automatic test_full_pop();
        tx_words = '{32'($urandom_range(0, 255))};
        frame(0, 0, 0, 1'b1);
        n_checks++;
        if (rx_level0 !== 3'd4 || overflow0 !== 1'b0) begin
            n_fail++;
            $display("FAIL full push+pop: level=%0d ovf=%0d expected 4 0", rx_level0, overflow0);
        end
        drain(0, "full_pop");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            tx_words.delete();
            for (int i = 0; i < $urandom_range(1, 3); i++) tx_words.push_back($urandom_range(0, 255));
            frame(0, $urandom_range(0, 7), $urandom, 1'b0);
            drain(0, "random_m0");
            tx_words.delete();
            for (int i = 0; i < $urandom_range(1, 2); i++) tx_words.push_back($urandom_range(0, 65535));
            frame(3, $urandom_range(0, 15), $urandom, 1'b0);
            drain(3, "random_m3");
        end
    endtask

    task automatic test_reset_mid();
        ssel0 = 1'b0;
        half();
        send_word(0, 32'h3C, 8, 1'b0);
        send_word(0, 32'hF0, 4, 1'b0);
        n_checks++;
        if (rx_level0 !== 3'd1) begin
            n_fail++;
            $display("FAIL pre-reset level: got %0d expected 1", rx_level0);
        end
        RESET_N = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check_reset_outputs("reset_mid");
        ssel0 = 1'b1;
        sck0  = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 RESET_N = 1'b1;
        q0.delete();
        q3.delete();
        ovf0_m = 0;
        repeat (4) @(posedge CLOCK_50);
        #1;
        check_reset_outputs("after_release");
        tx_words = '{32'hAA};
        frame(0, 0, 0, 1'b0);
        drain(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_mode0_frame();
        test_mode3_lsb();
        test_partial();
        test_overflow();
        test_full_pop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 The module SHALL have parameter WORD_W, default 8, meaning bits per received word (range 4..32).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, at least 2).
REQ-003 The module SHALL have parameter CPOL, default 0, meaning SCK idle level.
REQ-004 The module SHALL have parameter CPHA, default 0, meaning sample phase (0 = leading edge, 1 = trailing edge).
REQ-005 The module SHALL have parameter MSB_FIRST, default 1, meaning bit order of each word (1 = MSB first).
REQ-006 The module SHALL have port CLOCK_50  in  1  system clock; the single clock of the block.
REQ-007 The module SHALL have port RESET_N  in  1  reset, asynchronous and active-low.
REQ-008 The module SHALL have ports SCK, MOSI, SSEL  in  1 each  raw SPI pins, asynchronous to CLOCK_50; SSEL is active-low.
REQ-009 The module SHALL have port rx_data  out  WORD_W  FIFO head word, first-word-fall-through.
REQ-010 The module SHALL have port rx_first  out  1  high when the head word is the first word of its frame.
REQ-011 The module SHALL have port rx_valid  out  1  FIFO not empty.
REQ-012 The module SHALL have port rx_ready  in  1  consumer pop; a pop occurs when rx_valid and rx_ready are both high.
REQ-013 The module SHALL have port rx_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 The module SHALL have port frame_active  out  1  synchronised SSEL is low.
REQ-015 The module SHALL have port frame_end  out  1  one-cycle pulse on the synchronised SSEL rising edge.
REQ-016 The module SHALL have port overflow  out  1  sticky; set when a completed word is dropped.
REQ-017 The module SHALL have port clr_overflow  in  1  synchronous clear of overflow.

Function
REQ-018 SCK, MOSI and SSEL SHALL each pass through a two-flop synchroniser plus one history flop; edges are detected between stage 2 and stage 3.
REQ-019 Supported SCK: high and low phases SHALL each be at least 3 CLOCK_50 periods; MOSI SHALL be stable across the sampling edge ±2 periods.
REQ-020 The sampling edge SHALL be rising SCK when CPOL==CPHA and falling SCK otherwise; SCK edges while SSEL is high SHALL be ignored.
REQ-021 On a sampling edge the synchronised MOSI SHALL be shifted in, at the LSB end when MSB_FIRST=1 and at the MSB end otherwise, and the bit counter SHALL increment.
REQ-022 When the bit counter reaches WORD_W, the assembled word and the first-flag SHALL be pushed on that same cycle and the counter SHALL return to 0.
REQ-023 rx_valid SHALL assert on the cycle after the push, i.e. within 4 CLOCK_50 cycles of the final sampling SCK pin edge.
REQ-024 A synchronised SSEL falling edge SHALL clear the bit counter and shift register and set the first-flag; the first-flag SHALL clear after the first push of the frame.
REQ-025 A synchronised SSEL rising edge SHALL discard any partial word (no push, no overflow) and pulse frame_end for exactly one cycle.
REQ-026 A push into a full FIFO SHALL be dropped and overflow SHALL be set; a push and a pop on the same cycle with the FIFO full SHALL both succeed, leaving rx_level unchanged.
REQ-027 A simultaneous push and pop at any level SHALL leave rx_level unchanged; a pop when the FIFO is empty SHALL be ignored.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-029 When set and clear coincide on overflow, set SHALL win.

Reset
REQ-030 While RESET_N is low, all synchroniser flops SHALL hold idle values (SCK=CPOL, SSEL=1, MOSI=0), the FIFO SHALL be empty, and the counter and shift register SHALL be 0.
REQ-031 Reset outputs SHALL be: rx_valid=0, rx_level=0, rx_data=0, rx_first=0, frame_active=0, frame_end=0, overflow=0.
REQ-032 After a reset released mid-frame, the partial word SHALL be lost, and words SHALL only be accepted after the next SSEL falling edge.

Structure
REQ-033 A shared package spi_pkg SHALL hold the SPI mode encodings (MODE0..MODE3 as {CPOL,CPHA}) and the minimum SCK phase constant (3).
REQ-034 The FIFO SHALL be a sub-module sync_fifo, parametrised by width (WORD_W+1) and depth, with a first-word-fall-through output.

Verification
REQ-035 Mode 0, 8-bit, 1 us SCK half-period: frame AA,55,00 -> three pops AA/first=1, 55/first=0, 00/first=0; one frame_end pulse.
REQ-036 Mode 3, WORD_W=16, MSB_FIRST=0: frame of bytes 34,12 -> one word 0x1234 (first bit received is the LSB); frame_active is high for the whole frame.
REQ-037 SSEL rises after 5 bits of 0xFF -> no push, rx_level=0, overflow=0; the next frame's 0x0F is received intact with first=1.
REQ-038 FIFO_DEPTH=4, rx_ready=0, 6 words sent -> rx_level=4, overflow=1, and the head word is word 1; clr_overflow clears overflow.
REQ-039 Full FIFO with rx_ready=1 at the cycle a push lands -> rx_level stays 4 and overflow stays 0.
REQ-040 RESET_N pulsed low mid-word -> all outputs return to reset values; a subsequent frame AA is received correctly.
